// File: rtl/led_chaser_monitor.sv
// Observer for the bouncing one-hot LED bus: decodes position and direction,
// counts reversals and latches the first protocol violation until cleared.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no LED tracked; waiting for a one-hot pattern to acquire
// S_TRACK | following a single lit LED, validating adjacent steps
// S_ERROR | violation latched; bus ignored until clear_i or reset
module led_chaser_monitor #(
  parameter int LED_COUNT = 10,
  parameter int POS_W     = 4,
  parameter int BOUNCE_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [LED_COUNT-1:0] ledr_i,
  input  logic                 clear_i,
  output logic                 active_o,
  output logic [POS_W-1:0]     pos_o,
  output logic                 dir_o,
  output logic                 dir_valid_o,
  output logic                 step_o,
  output logic                 bounce_o,
  output logic [BOUNCE_W-1:0]  bounce_cnt_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_ERROR = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MULTI = 2'b01;
  localparam logic [1:0] ERR_JUMP  = 2'b10;

  state_e state_q, state_d;

  logic [LED_COUNT-1:0] in_q, prev_q, shl, shr;
  logic                 is_zero, is_onehot, is_multi, changed;
  logic                 step_left, step_right;
  logic [POS_W-1:0]     idx;

  logic                pos_upd;
  logic [POS_W-1:0]    pos_d;
  logic                dir_d, dir_valid_d, step_d, bounce_d, err_d, active_d;
  logic [BOUNCE_W-1:0] bounce_cnt_d;
  logic [1:0]          err_code_d;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      in_q   <= '0;
      prev_q <= '0;
    end else begin
      in_q   <= ledr_i;
      prev_q <= in_q;
    end
  end

  assign is_zero   = (in_q == '0);
  assign is_onehot = !is_zero && ((in_q & (in_q - LED_COUNT'(1))) == '0);
  assign is_multi  = !is_zero && !is_onehot;
  assign changed   = (in_q != prev_q);
  // Shifts stay LED_COUNT wide so a bit pushed past either end never matches.
  assign shl        = prev_q << 1;
  assign shr        = prev_q >> 1;
  assign step_left  = is_onehot && (in_q == shl);
  assign step_right = is_onehot && (in_q == shr);

  always_comb begin
    idx = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      if (in_q[i]) idx = POS_W'(i);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_multi)       state_d = S_ERROR;
        else if (is_onehot) state_d = S_TRACK;
      end
      S_TRACK: begin
        if (changed) begin
          if (is_zero)                       state_d = S_IDLE;
          else if (!(step_left || step_right)) state_d = S_ERROR;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
    if (clear_i) state_d = S_IDLE;
  end

  always_comb begin
    pos_upd      = 1'b0;
    pos_d        = pos_o;
    dir_d        = dir_o;
    dir_valid_d  = dir_valid_o;
    bounce_cnt_d = bounce_cnt_o;
    err_d        = err_o;
    err_code_d   = err_code_o;
    step_d       = 1'b0;
    bounce_d     = 1'b0;
    active_d     = (state_d == S_TRACK);
    if (clear_i) begin
      pos_d        = '0;
      dir_d        = 1'b0;
      dir_valid_d  = 1'b0;
      bounce_cnt_d = '0;
      err_d        = 1'b0;
      err_code_d   = ERR_NONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (is_multi) begin
            err_d      = 1'b1;
            err_code_d = ERR_MULTI;
          end else if (is_onehot) begin
            pos_upd     = 1'b1;
            dir_valid_d = 1'b0;
          end
        end
        S_TRACK: begin
          if (changed) begin
            if (is_zero) begin
              dir_valid_d = 1'b0;
            end else if (step_left || step_right) begin
              pos_upd     = 1'b1;
              dir_d       = step_left;
              dir_valid_d = 1'b1;
              step_d      = 1'b1;
              if (dir_valid_o && (step_left != dir_o)) begin
                bounce_d = 1'b1;
                if (bounce_cnt_o != '1) bounce_cnt_d = bounce_cnt_o + BOUNCE_W'(1);
              end
            end else begin
              err_d       = 1'b1;
              err_code_d  = is_multi ? ERR_MULTI : ERR_JUMP;
              dir_valid_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
      if (pos_upd) pos_d = idx;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      active_o     <= 1'b0;
      pos_o        <= '0;
      dir_o        <= 1'b0;
      dir_valid_o  <= 1'b0;
      step_o       <= 1'b0;
      bounce_o     <= 1'b0;
      bounce_cnt_o <= '0;
      err_o        <= 1'b0;
      err_code_o   <= ERR_NONE;
    end else begin
      active_o     <= active_d;
      pos_o        <= pos_d;
      dir_o        <= dir_d;
      dir_valid_o  <= dir_valid_d;
      step_o       <= step_d;
      bounce_o     <= bounce_d;
      bounce_cnt_o <= bounce_cnt_d;
      err_o        <= err_d;
      err_code_o   <= err_code_d;
    end
  end

endmodule

// File: tb/tb_led_chaser_monitor.sv
// Bench for led_chaser_monitor: directed scenarios plus randomized chaser
// traffic, checked every cycle against a position-arithmetic reference model.
module tb_led_chaser_monitor;
  localparam int L  = 10;
  localparam int PW = 4;
  localparam int BW = 8;
  localparam int BS = 2;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic [L-1:0]  ledr_i;
  logic          clear_i;

  logic          active_o, dir_o, dir_valid_o, step_o, bounce_o, err_o;
  logic [PW-1:0] pos_o;
  logic [BW-1:0] bounce_cnt_o;
  logic [1:0]    err_code_o;

  logic          s_active, s_dir, s_dir_valid, s_step, s_bounce, s_err;
  logic [PW-1:0] s_pos;
  logic [BS-1:0] s_bounce_cnt;
  logic [1:0]    s_err_code;

  int n_checks = 0;
  int n_pass   = 0;
  int n_step   = 0;
  int n_bounce = 0;

  // Reference model: what the monitor should currently be reporting.
  logic [L-1:0] m_hist[2];
  bit  m_track, m_err;
  int  m_bounces;
  bit  e_active, e_dir, e_dv, e_step, e_bounce, e_err;
  int  e_pos, e_code;

  always #5 clk_i = ~clk_i;

  led_chaser_monitor #(.LED_COUNT(L), .POS_W(PW), .BOUNCE_W(BW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .ledr_i(ledr_i), .clear_i(clear_i),
    .active_o(active_o), .pos_o(pos_o), .dir_o(dir_o), .dir_valid_o(dir_valid_o),
    .step_o(step_o), .bounce_o(bounce_o), .bounce_cnt_o(bounce_cnt_o),
    .err_o(err_o), .err_code_o(err_code_o)
  );

  led_chaser_monitor #(.LED_COUNT(L), .POS_W(PW), .BOUNCE_W(BS)) dut_sat (
    .clk_i(clk_i), .reset_ni(reset_ni), .ledr_i(ledr_i), .clear_i(clear_i),
    .active_o(s_active), .pos_o(s_pos), .dir_o(s_dir), .dir_valid_o(s_dir_valid),
    .step_o(s_step), .bounce_o(s_bounce), .bounce_cnt_o(s_bounce_cnt),
    .err_o(s_err), .err_code_o(s_err_code)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int pos_of(input logic [L-1:0] v);
    for (int i = 0; i < L; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_hist[0] = '0; m_hist[1] = '0;
    m_track = 0; m_err = 0; m_bounces = 0;
    e_active = 0; e_dir = 0; e_dv = 0; e_step = 0; e_bounce = 0; e_err = 0;
    e_pos = 0; e_code = 0;
  endtask

  task automatic model_fault(input int code);
    m_err = 1; m_track = 0; e_err = 1; e_code = code; e_dv = 0;
  endtask

  // Called just after a rising edge, with the inputs that edge sampled.
  task automatic model_update();
    logic [L-1:0] cur, prv;
    int d;
    cur = m_hist[0]; prv = m_hist[1];
    e_step = 0; e_bounce = 0;
    if (clear_i) begin
      m_track = 0; m_err = 0; m_bounces = 0;
      e_dir = 0; e_dv = 0; e_err = 0; e_pos = 0; e_code = 0;
    end else if (m_err) begin
    end else if (!m_track) begin
      if ($countones(cur) > 1) model_fault(1);
      else if ($countones(cur) == 1) begin
        m_track = 1; e_pos = pos_of(cur); e_dv = 0;
      end
    end else if (cur != prv) begin
      if (cur == '0) begin
        m_track = 0; e_dv = 0;
      end else if ($countones(cur) > 1) begin
        model_fault(1);
      end else begin
        d = pos_of(cur) - pos_of(prv);
        if (d == 1 || d == -1) begin
          if (e_dv && ((d == 1) != e_dir)) begin
            e_bounce = 1; m_bounces++;
          end
          e_dir = (d == 1); e_dv = 1; e_step = 1; e_pos = pos_of(cur);
        end else begin
          model_fault(2);
        end
      end
    end
    e_active = m_track;
    m_hist[1] = m_hist[0];
    m_hist[0] = ledr_i;
  endtask

  task automatic compare_all();
    check("active", 32'(active_o), 32'(e_active));
    check("pos", 32'(pos_o), e_pos);
    check("dir", 32'(dir_o), 32'(e_dir));
    check("dir_valid", 32'(dir_valid_o), 32'(e_dv));
    check("step", 32'(step_o), 32'(e_step));
    check("bounce", 32'(bounce_o), 32'(e_bounce));
    check("bounce_cnt", 32'(bounce_cnt_o), sat(m_bounces, BW));
    check("bounce_cnt_sat", 32'(s_bounce_cnt), sat(m_bounces, BS));
    check("err", 32'(err_o), 32'(e_err));
    check("err_code", 32'(err_code_o), e_code);
    if (step_o) n_step++;
    if (bounce_o) n_bounce++;
  endtask

  // Entered and left at a falling edge.
  task automatic cyc(input logic [L-1:0] v, input logic clr);
    ledr_i = v; clear_i = clr;
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic hold(input logic [L-1:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(v, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_active"}, 32'(active_o), 0);
    check({tag, "_pos"}, 32'(pos_o), 0);
    check({tag, "_dir"}, 32'(dir_o), 0);
    check({tag, "_dv"}, 32'(dir_valid_o), 0);
    check({tag, "_step"}, 32'(step_o), 0);
    check({tag, "_bounce"}, 32'(bounce_o), 0);
    check({tag, "_cnt"}, 32'(bounce_cnt_o), 0);
    check({tag, "_cnt_sat"}, 32'(s_bounce_cnt), 0);
    check({tag, "_err"}, 32'(err_o), 0);
    check({tag, "_code"}, 32'(err_code_o), 0);
  endtask

  initial begin
    logic [L-1:0] v;
    int p, dirl, r, q;

    reset_ni = 1'b0; ledr_i = '0; clear_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    reset_ni = 1'b1;
    hold('0, 3);

    // Acquire at bit 0
    n_step = 0;
    hold(10'h001, 3);
    check("t1_active", 32'(active_o), 1);
    check("t1_pos", 32'(pos_o), 0);
    check("t1_dv", 32'(dir_valid_o), 0);
    check("t1_err", 32'(err_o), 0);
    check("t1_steps", n_step, 0);

    // Left sweep
    n_step = 0;
    v = 10'h001;
    for (int i = 0; i < 9; i++) begin
      v = v << 1;
      hold(v, 4);
    end
    check("t2_steps", n_step, 9);
    check("t2_dir", 32'(dir_o), 1);
    check("t2_pos", 32'(pos_o), 9);
    check("t2_cnt", 32'(bounce_cnt_o), 0);

    // Endpoint dwell then reversal
    n_step = 0; n_bounce = 0;
    hold(10'h200, 8);
    check("t3_dwell_steps", n_step, 0);
    check("t3_dwell_err", 32'(err_o), 0);
    hold(10'h100, 3);
    check("t3_steps", n_step, 1);
    check("t3_bounces", n_bounce, 1);
    check("t3_dir", 32'(dir_o), 0);
    check("t3_pos", 32'(pos_o), 8);
    check("t3_cnt", 32'(bounce_cnt_o), 1);

    // Jump error, frozen, clear and re-acquire
    v = 10'h100;
    for (int i = 0; i < 6; i++) begin
      v = v >> 1;
      hold(v, 2);
    end
    hold(10'h040, 3);
    check("t4_err", 32'(err_o), 1);
    check("t4_code", 32'(err_code_o), 2);
    check("t4_active", 32'(active_o), 0);
    n_step = 0;
    hold(10'h080, 2); hold(10'h100, 2); hold(10'h3ff, 2); hold(10'h000, 2);
    check("t4_frozen_code", 32'(err_code_o), 2);
    check("t4_frozen_pos", 32'(pos_o), 2);
    check("t4_frozen_steps", n_step, 0);
    cyc(10'h040, 1'b1);
    hold(10'h040, 2);
    check("t4_clr_err", 32'(err_o), 0);
    check("t4_clr_cnt", 32'(bounce_cnt_o), 0);
    check("t4_reacq_active", 32'(active_o), 1);
    check("t4_reacq_pos", 32'(pos_o), 6);

    // Multi-hot from IDLE, first code wins
    hold('0, 3);
    check("t5_idle", 32'(active_o), 0);
    hold(10'h003, 3);
    check("t5_code", 32'(err_code_o), 1);
    hold(10'h001, 2); hold(10'h002, 2);
    check("t5_err", 32'(err_o), 1);
    check("t5_code_kept", 32'(err_code_o), 1);
    cyc('0, 1'b1);
    hold('0, 2);

    // Saturation of the narrow counter, then asynchronous reset mid-sweep
    for (int i = 0; i < 7; i++) hold((i % 2 == 0) ? 10'h001 : 10'h002, 2);
    hold(10'h001, 2);
    check("t6_cnt", 32'(bounce_cnt_o), 5);
    check("t6_cnt_sat", 32'(s_bounce_cnt), 3);
    cyc(10'h002, 1'b0);
    #2 reset_ni = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk_i);
    reset_ni = 1'b1;

    // Randomized chaser traffic
    p = 0; dirl = 1;
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      if (r < 65) begin
        if (p == L - 1) dirl = 0;
        else if (p == 0) dirl = 1;
        p = dirl ? p + 1 : p - 1;
        v = L'(1) << p;
        hold(v, $urandom_range(1, 4));
      end else if (r < 75) begin
        hold(ledr_i, $urandom_range(1, 6));
      end else if (r < 81) begin
        hold('0, $urandom_range(1, 3));
      end else if (r < 86) begin
        v = (L'(1) << p) | (L'(1) << ((p + 3) % L));
        hold(v, 2);
      end else if (r < 91) begin
        q = (p + $urandom_range(2, L - 2)) % L;
        p = q;
        hold(L'(1) << p, 2);
      end else begin
        cyc(ledr_i, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_chaser_monitor.md
Name: led_chaser_monitor

Overview:
Observer for the bouncing one-hot LED bus on the DE10-Lite board. It samples the LED vector and decodes the lit position and direction of motion. It counts direction reversals (bounces) and flags protocol violations. Its outputs feed the 7-segment display path and the debug status LEDs.

Parameters:
LED_COUNT, 10, width of the observed LED bus
POS_W, 4, width of position index; must satisfy 2**POS_W >= LED_COUNT
BOUNCE_W, 8, width of saturating bounce counter

Ports:
clk_i  input  1  system clock
reset_ni  input  1  reset, asynchronous, active-low
ledr_i  input  LED_COUNT  observed LED vector, synchronous to clk_i
clear_i  input  1  synchronous clear of error, counters and state
active_o  output  1  exactly one LED currently lit and state is TRACK
pos_o  output  POS_W  index of lit LED (bit 0 = position 0)
dir_o  output  1  direction of last step: 1 = left (toward MSB), 0 = right
dir_valid_o  output  1  at least one step seen since entering TRACK
step_o  output  1  one-cycle pulse per valid adjacent step
bounce_o  output  1  one-cycle pulse per direction reversal
bounce_cnt_o  output  BOUNCE_W  reversals since reset/clear, saturating
err_o  output  1  sticky error flag
err_code_o  output  2  00 none, 01 multi-hot, 10 non-adjacent jump

Behaviour:
- Reset (async, reset_ni low): state IDLE; sample register cleared. All outputs go to 0 immediately: pos_o, dir_o, dir_valid_o, active_o, step_o, bounce_o, bounce_cnt_o, err_o and err_code_o.
- Stage 1: in_q <= ledr_i every edge; prev_q <= in_q. The FSM compares in_q against prev_q, and all outputs are registered.
- Latency: an ledr_i change is visible on the outputs 2 clock edges later.
- Classification of in_q: ZERO (all 0), ONEHOT (popcount 1), MULTI (popcount >= 2).
- Change = (in_q != prev_q). When there is no change, state and outputs hold; step_o and bounce_o are 0.
- IDLE:
  - ONEHOT: go to TRACK; pos_o = index; active_o = 1; dir_valid_o = 0; no step_o.
  - MULTI: go to ERROR, err_code 01.
  - ZERO: stay in IDLE.
- TRACK, on change:
  - in_q == prev_q << 1: left step; dir_o = 1, step_o pulse.
  - in_q == prev_q >> 1: right step; dir_o = 0, step_o pulse.
  - On a step: pos_o updated, dir_valid_o = 1.
  - Reversal: if dir_valid_o was already 1 and the new dir differs from the old dir_o, pulse bounce_o in the same cycle as step_o. bounce_cnt_o increments and saturates at 2**BOUNCE_W-1.
  - ZERO: go to IDLE; active_o = 0, dir_valid_o = 0; pos_o and dir_o hold last values.
  - MULTI: go to ERROR, err_code 01.
  - Any other ONEHOT value (jump of more than one position): go to ERROR, err_code 10.
  - The shift comparison is truncated to LED_COUNT bits, so the MSB shifted out never matches as a step.
- ERROR: err_o = 1, active_o = 0, step_o and bounce_o = 0. err_code_o, pos_o and bounce_cnt_o are frozen. ledr_i is ignored. The first error code wins. Exit is only via clear_i or reset.
- clear_i (any state): next edge goes to IDLE with all outputs at reset values. clear_i has priority over any event in the same cycle. prev_q is not cleared; a lit LED is re-acquired as start (no step) on the following cycle.
- Dwell: the same pattern held for many cycles produces no events. The endpoint dwell of the chaser (LED held at bit LED_COUNT-1 or bit 0 for an extra period) must not generate steps or errors.

Test Plan:
1. Reset with ledr_i = 0, then ledr_i = 0x001 -> 2 edges later: active_o = 1, pos_o = 0, dir_valid_o = 0, step_o never pulsed, err_o = 0.
2. Left sweep 0x001..0x200, one shift every 4 cycles -> exactly 9 step_o pulses, dir_o = 1, final pos_o = 9, bounce_cnt_o = 0.
3. Hold 0x200 for 8 cycles, then 0x100 -> no events during the hold. Then one step_o and a coincident bounce_o pulse: dir_o = 0, pos_o = 8, bounce_cnt_o = 1.
4. In TRACK at 0x004, drive 0x040 -> err_o = 1, err_code_o = 10. Further ledr_i activity changes nothing. Pulse clear_i -> IDLE, err_o = 0, bounce_cnt_o = 0, and 0x040 is re-acquired with pos_o = 6.
5. From IDLE drive 0x003 -> err_code_o = 01. Then drive 0x001 and 0x002 -> still ERROR with code 01.
6. With BOUNCE_W = 2, run 5 reversals -> bounce_cnt_o saturates at 3. Assert reset_ni low mid-sweep -> all outputs 0 asynchronously, before the next clock edge.
